// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART register-bus arbiter.
// Combinational definitions only, no latency.
// No flow control of its own.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2,
      ST_GAP  = 2'd3
   } arb_state_e;

   localparam int          TIMEOUT_DEF = 32;
   localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

endpackage

// File: rtl/uart_rr_arb.sv
// Two-way round-robin grant selection for the UART register arbiter.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to consume the grant.
module uart_rr_arb (
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       gnt_vld,
   output logic       gnt_idx
);

   // Under contention the requester not served last wins; a lone requester always wins.
   always_comb begin
      gnt_vld = |req;
      gnt_idx = 1'b0;
      if (req == 2'b11) begin
         gnt_idx = ~last_gnt;
      end else begin
         gnt_idx = req[1];
      end
   end

endmodule

// File: rtl/uart_reg_arb.sv
// Arbitrates two requesters onto one UART register bus with an ack timeout.
// reg_cs rises one cycle after req_cs; completion pulses one cycle after reg_ack/timeout.
// One transaction at a time; losers keep req_cs high until served.
module uart_reg_arb
   import uart_arb_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF  // legal range 2..255
) (
   input  logic                app_clk,
   input  logic                reset_ssn,
   input  logic [1:0]          req_cs,
   input  logic [1:0]          req_wr,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   input  logic [2*BE_W-1:0]   req_be,
   output logic [DATA_W-1:0]   req_rdata,
   output logic [1:0]          req_ack,
   output logic [1:0]          req_err,
   output logic                reg_cs,
   output logic                reg_wr,
   output logic [ADDR_W-1:0]   reg_addr,
   output logic [DATA_W-1:0]   reg_wdata,
   output logic [BE_W-1:0]     reg_be,
   input  logic [DATA_W-1:0]   reg_rdata,
   input  logic                reg_ack
);

   // Last BUSY cycle before the wait is abandoned.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   arb_state_e          state_q;
   logic                last_gnt_q;
   logic [7:0]          cnt_q;
   logic [7:0]          cnt_d;
   logic                reg_cs_q;
   logic                reg_wr_q;
   logic [ADDR_W-1:0]   reg_addr_q;
   logic [DATA_W-1:0]   reg_wdata_q;
   logic [BE_W-1:0]     reg_be_q;
   logic [DATA_W-1:0]   req_rdata_q;
   logic [1:0]          req_ack_q;
   logic [1:0]          req_err_q;

   logic                arb_vld;
   logic                arb_idx;
   logic                win_wr;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_wdata;
   logic [BE_W-1:0]     win_be;
   logic [1:0]          gnt_onehot;

   uart_rr_arb u_rr_arb (
      .req      (req_cs),
      .last_gnt (last_gnt_q),
      .gnt_vld  (arb_vld),
      .gnt_idx  (arb_idx)
   );

   // Select the winning requester's fields and derive helper values for the FSM.
   always_comb begin
      win_wr     = arb_idx ? req_wr[1]                  : req_wr[0];
      win_addr   = arb_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      win_wdata  = arb_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      win_be     = arb_idx ? req_be[2*BE_W-1:BE_W]      : req_be[BE_W-1:0];
      cnt_d      = cnt_q + 8'd1;
      // last_gnt_q doubles as the index of the requester currently being served
      gnt_onehot = {last_gnt_q, ~last_gnt_q};
   end

   // Transaction FSM; every output is a register updated here.
   always_ff @(posedge app_clk or negedge reset_ssn) begin
      if (!reset_ssn) begin
         state_q     <= ST_IDLE;
         last_gnt_q  <= 1'b1;
         cnt_q       <= '0;
         reg_cs_q    <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_be_q    <= '0;
         req_rdata_q <= '0;
         req_ack_q   <= '0;
         req_err_q   <= '0;
      end else begin
         // completion pulses are single-cycle by default
         req_ack_q <= '0;
         req_err_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (arb_vld) begin
                  last_gnt_q  <= arb_idx;
                  cnt_q       <= '0;
                  reg_cs_q    <= 1'b1;
                  reg_wr_q    <= win_wr;
                  reg_addr_q  <= win_addr;
                  reg_wdata_q <= win_wdata;
                  reg_be_q    <= win_be;
                  state_q     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // an ack arriving on the final timeout cycle still counts as success
               if (reg_ack) begin
                  req_rdata_q <= reg_rdata;
                  req_ack_q   <= gnt_onehot;
                  reg_cs_q    <= 1'b0;
                  state_q     <= ST_RESP;
               end else if (cnt_q == CNT_LAST) begin
                  req_rdata_q <= ERR_DATA;
                  req_err_q   <= gnt_onehot;
                  reg_cs_q    <= 1'b0;
                  state_q     <= ST_RESP;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_RESP: begin
               state_q <= ST_GAP;
            end
            ST_GAP: begin
               // gives the served requester time to drop req_cs before re-arbitrating
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign reg_cs    = reg_cs_q;
   assign reg_wr    = reg_wr_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_be    = reg_be_q;
   assign req_rdata = req_rdata_q;
   assign req_ack   = req_ack_q;
   assign req_err   = req_err_q;

endmodule

// File: tb/tb_uart_reg_arb.sv
// Bench for uart_reg_arb: directed cases plus randomized rounds against a transaction model.
// Cycle-accurate expectations for reg_cs windows and response pulses.
// Emulates a downstream slave with programmable ack delay and stray acks while idle.
module tb_uart_reg_arb;

   localparam int          TO  = 32;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic        app_clk = 1'b0;
   logic        reset_ssn;
   logic [1:0]  req_cs;
   logic [1:0]  req_wr;
   logic [17:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_be;
   logic [31:0] req_rdata;
   logic [1:0]  req_ack;
   logic [1:0]  req_err;
   logic        reg_cs;
   logic        reg_wr;
   logic [8:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_be;
   logic [31:0] reg_rdata;
   logic        reg_ack;

   uart_reg_arb #(.TIMEOUT(TO)) dut (
      .app_clk   (app_clk),
      .reset_ssn (reset_ssn),
      .req_cs    (req_cs),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .req_rdata (req_rdata),
      .req_ack   (req_ack),
      .req_err   (req_err),
      .reg_cs    (reg_cs),
      .reg_wr    (reg_wr),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_be    (reg_be),
      .reg_rdata (reg_rdata),
      .reg_ack   (reg_ack)
   );

   always #5 app_clk = ~app_clk;

   int n_chk = 0;
   int n_err = 0;

   // Transaction model state
   int          m_last;     // index of the requester granted last
   logic [31:0] m_rdata;    // value req_rdata must hold

   // Per-requester transaction descriptors
   logic        t_wr[2];
   logic [8:0]  t_addr[2];
   logic [31:0] t_wdata[2];
   logic [3:0]  t_be[2];
   int          t_dly[2];   // reg_cs-high cycle on which the slave acks (> TO: never)
   logic [31:0] t_ackd[2];

   // Slave emulation state
   int          cur_d = 0;
   logic [31:0] cur_ackd = '0;
   int          hi_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // One cycle: check response outputs at the negedge, then drive the slave side.
   task automatic cyc(input logic [1:0] exp_ack, input logic [1:0] exp_err);
      @(negedge app_clk);
      chk("req_ack", 64'(req_ack), 64'(exp_ack));
      chk("req_err", 64'(req_err), 64'(exp_err));
      chk("req_rdata", 64'(req_rdata), 64'(m_rdata));
      if (reg_cs) begin
         hi_cnt++;
         reg_ack   = (hi_cnt == cur_d);
         reg_rdata = (hi_cnt == cur_d) ? cur_ackd : $urandom;
      end else begin
         hi_cnt    = 0;
         reg_ack   = 1'($urandom_range(0, 1));
         reg_rdata = $urandom;
      end
   endtask

   task automatic drive_req(input int i);
      req_wr[i]             = t_wr[i];
      req_addr[9*i +: 9]    = t_addr[i];
      req_wdata[32*i +: 32] = t_wdata[i];
      req_be[4*i +: 4]      = t_be[i];
   endtask

   task automatic rand_fields(input int i);
      t_wr[i]    = 1'($urandom_range(0, 1));
      t_addr[i]  = 9'($urandom);
      t_wdata[i] = $urandom;
      t_be[i]    = 4'($urandom);
      t_ackd[i]  = $urandom;
      case ($urandom_range(0, 3))
         0:       t_dly[i] = $urandom_range(1, 5);
         1:       t_dly[i] = $urandom_range(TO - 1, TO + 1);
         2:       t_dly[i] = TO + 10;
         default: t_dly[i] = $urandom_range(1, TO);
      endcase
   endtask

   // Raise the requesters in mask together and follow every transaction to completion.
   task automatic round(input logic [1:0] mask);
      logic [1:0] pend;
      logic [1:0] onehot;
      int         w;
      int         dur;
      bit         acked;
      bit         first;
      pend  = mask;
      first = 1'b1;
      for (int i = 0; i < 2; i++) if (mask[i]) drive_req(i);
      req_cs = mask;
      while (pend != 2'b00) begin
         if (pend == 2'b11) w = 1 - m_last;
         else               w = pend[1] ? 1 : 0;
         onehot   = (w == 1) ? 2'b10 : 2'b01;
         cur_d    = t_dly[w];
         cur_ackd = t_ackd[w];
         acked    = (t_dly[w] <= TO);
         dur      = acked ? t_dly[w] : TO;
         if (!first) begin
            repeat (2) begin
               cyc(2'b00, 2'b00);
               chk("gap_cs", 64'(reg_cs), 64'(0));
            end
         end
         for (int k = 0; k < dur; k++) begin
            cyc(2'b00, 2'b00);
            chk("busy_cs", 64'(reg_cs), 64'(1));
            chk("reg_wr", 64'(reg_wr), 64'(t_wr[w]));
            chk("reg_addr", 64'(reg_addr), 64'(t_addr[w]));
            chk("reg_wdata", 64'(reg_wdata), 64'(t_wdata[w]));
            chk("reg_be", 64'(reg_be), 64'(t_be[w]));
            if (k == 0) begin
               // winner's bus changes once submitted; the latched transaction must not
               req_wr[w]             = ~t_wr[w];
               req_addr[9*w +: 9]    = 9'($urandom);
               req_wdata[32*w +: 32] = $urandom;
               req_be[4*w +: 4]      = 4'($urandom);
            end
         end
         m_rdata = acked ? t_ackd[w] : ERR;
         m_last  = w;
         cyc(acked ? onehot : 2'b00, acked ? 2'b00 : onehot);
         chk("resp_cs", 64'(reg_cs), 64'(0));
         req_cs[w] = 1'b0;
         pend[w]   = 1'b0;
         first     = 1'b0;
      end
      repeat (2) begin
         cyc(2'b00, 2'b00);
         chk("idle_cs", 64'(reg_cs), 64'(0));
      end
   endtask

   initial begin
      reset_ssn = 1'b0;
      req_cs    = '0;
      req_wr    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      reg_rdata = '0;
      reg_ack   = 1'b0;
      m_last    = 1;
      m_rdata   = '0;

      repeat (3) @(negedge app_clk);
      chk("rst_reg_cs", 64'(reg_cs), 64'(0));
      chk("rst_reg_wr", 64'(reg_wr), 64'(0));
      chk("rst_reg_addr", 64'(reg_addr), 64'(0));
      chk("rst_reg_wdata", 64'(reg_wdata), 64'(0));
      chk("rst_reg_be", 64'(reg_be), 64'(0));
      chk("rst_req_rdata", 64'(req_rdata), 64'(0));
      chk("rst_req_ack", 64'(req_ack), 64'(0));
      chk("rst_req_err", 64'(req_err), 64'(0));
      reset_ssn = 1'b1;
      repeat (2) cyc(2'b00, 2'b00);

      // Two-way contention straight after reset: req0, then req1
      rand_fields(0); rand_fields(1);
      t_addr[0] = 9'h011; t_addr[1] = 9'h122;
      t_dly[0] = 3; t_dly[1] = 5;
      round(2'b11);

      // Repeat contention: req1 went last, so req0 again
      rand_fields(0); rand_fields(1);
      t_addr[0] = 9'h033; t_addr[1] = 9'h144;
      t_dly[0] = 2; t_dly[1] = 1;
      round(2'b11);

      // Req0 read at 0x004, ack three cycles after reg_cs rises
      rand_fields(0);
      t_wr[0] = 1'b0; t_addr[0] = 9'h004; t_dly[0] = 4; t_ackd[0] = 32'h0000_0055;
      round(2'b01);

      // Req1 write 0x040 / 0xA5 / be 0x1
      rand_fields(1);
      t_wr[1] = 1'b1; t_addr[1] = 9'h040; t_wdata[1] = 32'h0000_00A5; t_be[1] = 4'h1; t_dly[1] = 6;
      round(2'b10);

      // No ack at all: timeout after TO cycles of reg_cs
      rand_fields(0);
      t_dly[0] = TO + 20;
      round(2'b01);

      // Ack on the last permitted cycle beats the timeout
      rand_fields(1);
      t_dly[1] = TO;
      round(2'b10);

      // Reset in the middle of BUSY aborts the transaction silently
      rand_fields(0);
      drive_req(0);
      cur_d  = 1000;
      req_cs = 2'b01;
      cyc(2'b00, 2'b00);
      chk("pre_rst_cs", 64'(reg_cs), 64'(1));
      repeat (5) cyc(2'b00, 2'b00);
      reset_ssn = 1'b0;
      req_cs    = 2'b00;
      m_rdata   = '0;
      m_last    = 1;
      #1;
      chk("mid_rst_cs", 64'(reg_cs), 64'(0));
      chk("mid_rst_rdata", 64'(req_rdata), 64'(0));
      @(negedge app_clk);
      reset_ssn = 1'b1;
      repeat (TO + 4) begin
         cyc(2'b00, 2'b00);
         chk("post_rst_cs", 64'(reg_cs), 64'(0));
      end

      // Contention after the mid-transaction reset: req0 again
      rand_fields(0); rand_fields(1);
      t_addr[0] = 9'h055; t_addr[1] = 9'h166;
      t_dly[0] = 2; t_dly[1] = 2;
      round(2'b11);

      // Randomized rounds
      for (int r = 0; r < 40; r++) begin
         repeat ($urandom_range(0, 3)) begin
            cyc(2'b00, 2'b00);
            chk("idle_cs", 64'(reg_cs), 64'(0));
         end
         rand_fields(0);
         rand_fields(1);
         round(2'($urandom_range(1, 3)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
